// File: rtl/pe_result_packer_if.sv
// ----------------------------------------------------------------------------
// pe_result_packer_if
//
// Bundles the input beat handshake, the flush request and the output word
// handshake of pe_result_packer.
//
// Handshake rule, used on both sides: a transfer happens on the rising clock
// edge where valid && ready are both high. The source holds its payload
// stable while valid is high and ready is low. Ready may depend
// combinationally on valid in the same cycle.
//
// Signals
//   in_valid     upstream -> packer  input beat valid
//   in_ready     packer -> upstream  input beat accepted this cycle
//   in_sel_bit   upstream -> packer  1: beat carries bit_in, 0: data_in
//   bit_in       upstream -> packer  decision bit
//   data_in      upstream -> packer  signed pass-through value
//   flush        upstream -> packer  one-cycle request to emit a partial word
//   out_valid    packer -> buffer    output register holds a word
//   out_ready    buffer -> packer    downstream takes the word
//   out_data     packer -> buffer    packed bits or pass-through value
//   out_is_bits  packer -> buffer    1: out_data is a packed-bit word
//   out_nbits    packer -> buffer    valid bit count of a packed word
//
// Modports
//   master  upstream / output-buffer side (drives inputs, takes outputs)
//   slave   the packer itself
// ----------------------------------------------------------------------------
interface pe_result_packer_if #(
    parameter int WIDTH  = 24,
    parameter int PACK_N = 24
);
    localparam int NB_W = $clog2(PACK_N + 1);

    logic             in_valid;
    logic             in_ready;
    logic             in_sel_bit;
    logic             bit_in;
    logic [WIDTH-1:0] data_in;
    logic             flush;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_is_bits;
    logic [NB_W-1:0]  out_nbits;

    modport master (
        output in_valid,
        output in_sel_bit,
        output bit_in,
        output data_in,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_is_bits,
        input  out_nbits
    );

    modport slave (
        input  in_valid,
        input  in_sel_bit,
        input  bit_in,
        input  data_in,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_is_bits,
        output out_nbits
    );
endinterface

// File: rtl/pe_result_packer.sv
// ----------------------------------------------------------------------------
// pe_result_packer
//
// Downstream stage of the PE threshold/demux block. Each accepted beat is
// either a 1-bit threshold decision or a signed WIDTH-bit pass-through value.
// Decision bits are packed LSB-first into PACK_N-bit words; pass-through
// values are forwarded unchanged. All results leave through one registered
// valid/ready output toward the PE output buffer.
//
// Parameters
//   WIDTH   data width of the pass-through value and of the output word
//   PACK_N  decision bits per full packed word, 1..WIDTH
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards any partial word
//   bus    pe_result_packer_if.slave (input beats, flush, output word)
//
// Ordering
//   A pass-through beat that arrives while decision bits are still being
//   collected is held off until the partial bit word has been loaded into the
//   output register, so results leave in the order they were presented.
//   A flush that finds the output register busy is remembered in
//   flush_pending and served on the first cycle the register frees up.
// ----------------------------------------------------------------------------
module pe_result_packer #(
    parameter int WIDTH  = 24,
    parameter int PACK_N = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    pe_result_packer_if.slave bus
);
    localparam int NB_W = $clog2(PACK_N + 1);
    localparam logic [NB_W-1:0] LAST_IDX = NB_W'(PACK_N - 1);
    localparam logic [NB_W-1:0] FULL_CNT = NB_W'(PACK_N);

    // Bit accumulator: bits at positions >= cnt are always 0, which gives
    // the zero fill of partial words for free.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [NB_W-1:0]  cnt;
    logic [NB_W-1:0]  cnt_next;
    logic             flush_pending;
    logic             flush_pending_next;

    // Output register
    logic             out_valid_q;
    logic             out_valid_next;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_next;
    logic             out_is_bits_q;
    logic             out_is_bits_next;
    logic [NB_W-1:0]  out_nbits_q;
    logic [NB_W-1:0]  out_nbits_next;

    // Per-cycle decode
    logic             slot_free;
    logic             mode_hold;
    logic             in_ready_c;
    logic             accept;
    logic             emit_partial;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] acc_with_bit;

    always_comb begin
        // The output register can take a new word when it is empty or its
        // current word leaves on this edge.
        slot_free    = !out_valid_q || bus.out_ready;

        // A value beat must not overtake bits already collected.
        mode_hold    = bus.in_valid && !bus.in_sel_bit && (cnt != '0);

        in_ready_c   = slot_free && !bus.flush && !flush_pending && !mode_hold;
        accept       = bus.in_valid && in_ready_c;

        // Partial word leaves on an explicit flush, a remembered flush, or to
        // make room for a waiting value beat. Nothing to emit when cnt == 0.
        emit_partial = slot_free && (cnt != '0) &&
                       (bus.flush || flush_pending || mode_hold);

        bit_mask     = WIDTH'(bus.bit_in) << cnt;
        acc_with_bit = acc | bit_mask;
    end

    always_comb begin
        acc_next           = acc;
        cnt_next           = cnt;
        flush_pending_next = flush_pending;
        out_valid_next     = out_valid_q;
        out_data_next      = out_data_q;
        out_is_bits_next   = out_is_bits_q;
        out_nbits_next     = out_nbits_q;

        if (slot_free) begin
            // Any pending flush is served this cycle (or had nothing to emit).
            flush_pending_next = 1'b0;
            // Default: the register empties unless something new is loaded.
            out_valid_next     = 1'b0;

            if (emit_partial) begin
                out_valid_next   = 1'b1;
                out_data_next    = acc;
                out_is_bits_next = 1'b1;
                out_nbits_next   = cnt;
                acc_next         = '0;
                cnt_next         = '0;
            end else if (accept && !bus.in_sel_bit) begin
                out_valid_next   = 1'b1;
                out_data_next    = bus.data_in;
                out_is_bits_next = 1'b0;
                out_nbits_next   = '0;
            end else if (accept && bus.in_sel_bit) begin
                if (cnt == LAST_IDX) begin
                    // Word completes: emit it including the new bit and
                    // restart the accumulator on the same edge.
                    out_valid_next   = 1'b1;
                    out_data_next    = acc_with_bit;
                    out_is_bits_next = 1'b1;
                    out_nbits_next   = FULL_CNT;
                    acc_next         = '0;
                    cnt_next         = '0;
                end else begin
                    acc_next = acc_with_bit;
                    cnt_next = cnt + 1'b1;
                end
            end
        end else if (bus.flush) begin
            flush_pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            cnt           <= '0;
            flush_pending <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_is_bits_q <= 1'b0;
            out_nbits_q   <= '0;
        end else begin
            acc           <= acc_next;
            cnt           <= cnt_next;
            flush_pending <= flush_pending_next;
            out_valid_q   <= out_valid_next;
            out_data_q    <= out_data_next;
            out_is_bits_q <= out_is_bits_next;
            out_nbits_q   <= out_nbits_next;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_is_bits = out_is_bits_q;
    assign bus.out_nbits   = out_nbits_q;

endmodule

// File: doc/pe_result_packer.md
Name: pe_result_packer

Overview:
- Downstream stage of the PE threshold/demux block.
- Accepts one beat per handshake: either a 1-bit threshold decision or a pass-through signed 24-bit value.
- Packs decision bits LSB-first into WIDTH-bit words and forwards pass-through values unchanged.
- Drives one registered valid/ready output toward the PE output buffer.

Parameters:
- WIDTH, 24, data width of the pass-through value and of the output word.
- PACK_N, 24, decision bits per full packed word; legal range 1..WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_sel_bit  input  1  1: beat carries bit_in; 0: beat carries data_in.
- bit_in  input  1  decision bit; meaningful when in_sel_bit=1.
- data_in  input  WIDTH  signed pass-through value; meaningful when in_sel_bit=0.
- flush  input  1  single-cycle request to emit any partial packed word.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- out_data  output  WIDTH  packed bits (zero-filled above out_nbits) or pass-through value.
- out_is_bits  output  1  1: out_data is a packed-bit word; 0: pass-through value.
- out_nbits  output  $clog2(PACK_N+1)  number of valid bits in a packed word; 0 for pass-through.

Behaviour:
- Reset, asynchronous on rst_n low, immediate:
  - out_valid, out_data, out_is_bits and out_nbits go to 0.
  - Internal bit accumulator, bit count cnt and flush_pending go to 0.
  - Reset mid-word discards any partial word; no output is produced.
- slot_free = !out_valid || out_ready.
- Output register is loaded only when slot_free. While out_valid && !out_ready, all out_* signals hold stable.
- in_ready = slot_free && !flush && !flush_pending && !(in_valid && !in_sel_bit && cnt != 0).
  - in_ready is combinational from registers and the current-cycle inputs.
- Pass-through beat (in_sel_bit=0, accepted):
  - Next cycle: out_data=data_in, out_is_bits=0, out_nbits=0, out_valid=1.
  - Latency 1 cycle.
- Bit beat (in_sel_bit=1, accepted):
  - acc[cnt] <= bit_in, then cnt <= cnt+1.
  - If cnt was PACK_N-1, next cycle emits out_data = {zeros, acc with new bit}, out_is_bits=1, out_nbits=PACK_N, out_valid=1. Same edge clears cnt and acc.
  - Back-to-back full words sustain one beat per cycle when out_ready stays high.
- Mode switch: a pass-through beat presented while cnt != 0 is held off (in_ready=0).
  - Packer auto-flushes the partial word (out_nbits=cnt) as soon as slot_free, clearing cnt.
  - The beat is accepted on a later cycle, so order is preserved: partial bit word, then the value.
- Flush:
  - If flush is high and slot_free: emit the partial word when cnt != 0; do nothing when cnt == 0.
  - If flush is high and the slot is busy: set flush_pending. The partial word emits the first cycle slot_free is true, then flush_pending clears.
  - Flush has priority over input in the same cycle; no beat is accepted that cycle.
  - Flush with cnt=0 and flush_pending=0 produces no output.
- Zero fill: partial-word bits at positions >= out_nbits are 0.
- Decision bits are never dropped or duplicated. Total bits out equals total bit beats accepted.
- No arithmetic beyond the counter; cnt never exceeds PACK_N-1 at rest.

Test Plan:
- Reset release, then PACK_N=8, 8 bit beats 1,0,1,1,0,0,1,0, out_ready=1 -> one word: out_data=0x4D, out_is_bits=1, out_nbits=8, one cycle after the 8th accept.
- Pass-through beat data_in=-5 (0xFFFFFB), cnt=0 -> next cycle out_data=0xFFFFFB, out_is_bits=0, out_nbits=0.
- PACK_N=8: bits 1,1,1, then a pass-through beat 0x000123 -> first out_data=0x07, out_nbits=3, then 0x000123. in_ready=0 for the value until the partial word is loaded.
- Backpressure: out_ready=0 with out_valid=1, then flush while cnt=5 -> out_* stay stable, in_ready=0. After out_ready rises, the partial word (out_nbits=5) follows the held word.
- Flush with cnt=0 -> out_valid stays 0; in_ready=0 only in the flush cycle.
- Assert rst_n low after 4 accepted bits, then release -> out_valid=0 and no partial word appears. The next 8 bits form a clean word with out_nbits=8.
